noc_rx_monitor: RTL and testbench
=================================

Name: noc_rx_monitor

Overview:
- Synthesisable, parametrised receive-side monitor for the HNoC PE egress ports; replaces the hard-wired 4-PE packet-count-and-stop logic with a reusable block.
- Snoops every router-to-PE link (valid/ready/data) and counts accepted flits per PE and in total. Checks destination addresses, enforces an idle watchdog, and runs a completion state machine with a post-completion drain window.
- Instantiated alongside HNoC in benches and on-chip test harnesses; it never drives the links.

Parameters:
- NUM_PE, 4, number of monitored PE egress channels (1..64)
- DATA_W, 32, flit width in bits
- ADDR_LSB, 0, LSB of the destination-address field inside a flit
- ADDR_W, 2, width of the destination-address field; must be >= clog2(NUM_PE)
- CNT_W, 32, width of all counters
- EXPECTED_PKTS, 400, total accepted flits that constitute completion
- DRAIN_CYCLES, 1000, cycles watched for stray traffic after completion
- TIMEOUT_CYCLES, 100000, consecutive idle cycles in RUN that raise timeout

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_clear  in  1  synchronous soft clear; same effect as rst
- i_valid  in  NUM_PE  per-channel valid from router to PE
- i_ready  in  NUM_PE  per-channel ready from PE to router
- i_data  in  NUM_PE*DATA_W  flattened flits; channel k occupies [k*DATA_W +: DATA_W]
- o_per_pe_cnt  out  NUM_PE*CNT_W  flattened per-channel accepted counts
- o_total_cnt  out  CNT_W  total accepted flits
- o_cycle_cnt  out  CNT_W  cycles spent in RUN
- o_done  out  1  completion reached and drain finished cleanly or with errors flagged
- o_timeout  out  1  watchdog fired
- o_overflow  out  1  sticky: more flits than EXPECTED_PKTS were seen
- o_misroute  out  1  sticky: a flit arrived at the wrong PE
- o_misroute_pe  out  clog2(NUM_PE) (min 1)  channel index of the first misrouted flit
- o_state  out  2  current state encoding

Behaviour:
- Accept on channel k: i_valid[k] & i_ready[k] at a clk rising edge. Valid without ready is not counted.
- Reset or i_clear (rst wins; either alone suffices): all counters 0, all flags 0, o_misroute_pe 0, state RUN (o_state=0). Takes effect on the next edge and aborts any in-progress phase.
- States: RUN=0, DRAIN=1, DONE=2, TIMEOUT=3.
- RUN:
  - Counters and flags update one cycle after the accepting edge (registered outputs).
  - Per-channel counters increment by 1 per accept. The total increments by the popcount of accepts in that cycle, so simultaneous accepts on all channels add NUM_PE in one cycle.
  - All counters saturate at 2^CNT_W-1; no wrap.
  - o_cycle_cnt increments every RUN cycle.
  - Idle counter resets on any accept; otherwise it increments.
- RUN -> DRAIN when next total >= EXPECTED_PKTS.
  - If next total > EXPECTED_PKTS (crossing overshoot in one cycle), set o_overflow in the same cycle.
  - Drain counter loads 0.
- RUN -> TIMEOUT when the idle counter reaches TIMEOUT_CYCLES-1 and there is no accept this cycle. o_timeout=1 from entry; TIMEOUT is terminal until reset or clear.
- DRAIN:
  - Counters still count; any accept sets o_overflow.
  - After DRAIN_CYCLES cycles in DRAIN, go to DONE.
  - The watchdog is inactive; o_cycle_cnt freezes.
- DONE: o_done=1; terminal. Counters keep counting accepts. Any accept sets o_overflow.
- Misroute check, in every state:
  - An accept on channel k whose i_data[k*DATA_W+ADDR_LSB +: ADDR_W] != k sets o_misroute.
  - o_misroute_pe captures k on the first such event only.
  - If several channels misroute in the same first cycle, capture the lowest index.
- EXPECTED_PKTS=0: leave RUN on the first cycle after reset, go through DRAIN, then DONE.
- Outputs are purely observational; no combinational path from inputs to outputs.

Test Plan:
- NUM_PE=4, EXPECTED_PKTS=400: each PE accepts 100 correctly addressed flits at random intervals.
  - Required: o_total_cnt=400, each per-PE count=100, state DRAIN after the 400th flit, o_done=1 exactly DRAIN_CYCLES later, no error flags.
- All 4 channels accept every cycle with total at 398.
  - Required: total jumps to 402, o_overflow=1, state DRAIN in the same update.
- Valid held high with ready low on PE2 for 50 cycles, then one handshake.
  - Required: PE2 count increments by exactly 1.
- A flit with dest=3 is accepted on channel 1, and simultaneously a flit with dest=0 on channel 2.
  - Required: o_misroute=1, o_misroute_pe=1; a later misroute on channel 0 leaves it at 1.
- TIMEOUT_CYCLES=20: no traffic after 5 flits.
  - Required: o_timeout=1 and o_state=3 after 20 idle cycles; o_done stays 0.
- Assert i_clear during DRAIN with o_overflow set.
  - Required: next cycle all counts 0, flags 0, state RUN; a fresh run completes normally.

Source files
------------

// File: rtl/noc_rx_monitor.sv
// -----------------------------------------------------------------------------
// noc_rx_monitor
//
// Passive receive-side monitor for the HNoC PE egress links. It watches the
// router-to-PE valid/ready/data of every channel. It counts accepted flits per
// channel and in total. It also checks that each flit's destination field
// matches the channel it was delivered on. Completion is tracked with a small
// state machine:
//   RUN     -> counting, idle watchdog armed
//   DRAIN   -> expected count reached; stray traffic is flagged as overflow
//   DONE    -> drain window elapsed (terminal)
//   TIMEOUT -> watchdog expired while in RUN (terminal)
// rst or i_clear returns the block to RUN with everything zeroed.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_clear         synchronous soft clear (same effect as rst)
//   i_valid/i_ready per-channel handshake, NUM_PE bits each
//   i_data          flattened flits, channel k at [k*DATA_W +: DATA_W]
//   o_per_pe_cnt    flattened per-channel accepted counts, CNT_W each
//   o_total_cnt     total accepted flits
//   o_cycle_cnt     cycles spent in RUN
//   o_done          drain window finished
//   o_timeout       idle watchdog fired
//   o_overflow      sticky: more flits than EXPECTED_PKTS seen
//   o_misroute      sticky: a flit arrived on the wrong channel
//   o_misroute_pe   channel of the first misrouted flit
//   o_state         RUN=0, DRAIN=1, DONE=2, TIMEOUT=3
// All outputs are registered; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module noc_rx_monitor #(
    parameter int NUM_PE         = 4,
    parameter int DATA_W         = 32,
    parameter int ADDR_LSB       = 0,
    parameter int ADDR_W         = 2,
    parameter int CNT_W          = 32,
    parameter int EXPECTED_PKTS  = 400,
    parameter int DRAIN_CYCLES   = 1000,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int PE_W          = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic [NUM_PE-1:0]        i_valid,
    input  logic [NUM_PE-1:0]        i_ready,
    input  logic [NUM_PE*DATA_W-1:0] i_data,
    output logic [NUM_PE*CNT_W-1:0]  o_per_pe_cnt,
    output logic [CNT_W-1:0]         o_total_cnt,
    output logic [CNT_W-1:0]         o_cycle_cnt,
    output logic                     o_done,
    output logic                     o_timeout,
    output logic                     o_overflow,
    output logic                     o_misroute,
    output logic [PE_W-1:0]          o_misroute_pe,
    output logic [1:0]               o_state
);

    localparam int POP_W  = $clog2(NUM_PE + 1);
    // Terminal counts for the idle and drain counters. A zero-length window
    // behaves like a one-cycle window.
    localparam int TO_LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int DR_LIM = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam int IDLE_W = (TO_LIM > 0) ? $clog2(TO_LIM + 1) : 1;
    localparam int DRN_W  = (DR_LIM > 0) ? $clog2(DR_LIM + 1) : 1;
    localparam logic [CNT_W-1:0] EXP = CNT_W'(EXPECTED_PKTS);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   pe_cnt_q [NUM_PE];
    logic [CNT_W-1:0]   total_q;
    logic [CNT_W-1:0]   cycle_q;
    logic [IDLE_W-1:0]  idle_q;
    logic [DRN_W-1:0]   drain_q;
    logic               done_q;
    logic               timeout_q;
    logic               overflow_q;
    logic               misroute_q;
    logic [PE_W-1:0]    misroute_pe_q;

    logic [NUM_PE-1:0]  acc;
    logic               any_acc;
    logic [NUM_PE-1:0]  mis_vec;
    logic               mis_any;
    logic [PE_W-1:0]    mis_idx;
    logic               mis_found;
    logic [POP_W-1:0]   pop;
    logic [CNT_W:0]     total_sum;
    logic [CNT_W-1:0]   total_next;
    logic               unused_data;

    // Only the destination field of each flit is inspected.
    assign unused_data = ^i_data;

    assign acc     = i_valid & i_ready;
    assign any_acc = |acc;
    assign mis_any = |mis_vec;

    always_comb begin
        mis_vec = '0;
        pop     = '0;
        for (int unsigned k = 0; k < NUM_PE; k++) begin
            pop = pop + POP_W'(acc[k]);
            if (acc[k] && (i_data[k*DATA_W+ADDR_LSB +: ADDR_W] != ADDR_W'(k)))
                mis_vec[k] = 1'b1;
        end
    end

    // Lowest-index misrouted channel of this cycle.
    always_comb begin
        mis_idx   = '0;
        mis_found = 1'b0;
        for (int unsigned k = 0; k < NUM_PE; k++) begin
            if (mis_vec[k] && !mis_found) begin
                mis_idx   = PE_W'(k);
                mis_found = 1'b1;
            end
        end
    end

    // One spare bit on the sum detects carry-out for saturation.
    assign total_sum  = {1'b0, total_q} + (CNT_W+1)'(pop);
    assign total_next = total_sum[CNT_W] ? '1 : total_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            state_q       <= ST_RUN;
            for (int unsigned k = 0; k < NUM_PE; k++)
                pe_cnt_q[k] <= '0;
            total_q       <= '0;
            cycle_q       <= '0;
            idle_q        <= '0;
            drain_q       <= '0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            overflow_q    <= 1'b0;
            misroute_q    <= 1'b0;
            misroute_pe_q <= '0;
        end else begin
            // Accepts are counted in every state.
            for (int unsigned k = 0; k < NUM_PE; k++) begin
                if (acc[k] && (pe_cnt_q[k] != '1))
                    pe_cnt_q[k] <= pe_cnt_q[k] + CNT_W'(1);
            end
            total_q <= total_next;

            if (mis_any && !misroute_q) begin
                misroute_q    <= 1'b1;
                misroute_pe_q <= mis_idx;
            end

            case (state_q)
                ST_RUN: begin
                    if (cycle_q != '1)
                        cycle_q <= cycle_q + CNT_W'(1);
                    if (any_acc)
                        idle_q <= '0;
                    else
                        idle_q <= idle_q + IDLE_W'(1);

                    if (total_next >= EXP) begin
                        state_q <= ST_DRAIN;
                        drain_q <= '0;
                        if (total_next > EXP)
                            overflow_q <= 1'b1;
                    end else if (!any_acc && (idle_q == IDLE_W'(TO_LIM))) begin
                        state_q   <= ST_TIMEOUT;
                        timeout_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (any_acc)
                        overflow_q <= 1'b1;
                    if (drain_q == DRN_W'(DR_LIM)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + DRN_W'(1);
                    end
                end
                ST_DONE: begin
                    if (any_acc)
                        overflow_q <= 1'b1;
                end
                ST_TIMEOUT: begin
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        o_per_pe_cnt = '0;
        for (int unsigned k = 0; k < NUM_PE; k++)
            o_per_pe_cnt[k*CNT_W +: CNT_W] = pe_cnt_q[k];
    end

    assign o_total_cnt   = total_q;
    assign o_cycle_cnt   = cycle_q;
    assign o_done        = done_q;
    assign o_timeout     = timeout_q;
    assign o_overflow    = overflow_q;
    assign o_misroute    = misroute_q;
    assign o_misroute_pe = misroute_pe_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_noc_rx_monitor.sv
// -----------------------------------------------------------------------------
// tb_noc_rx_monitor
//
// Bench for noc_rx_monitor. A reference model tracks counts, idle time,
// drain window and flags as plain integers and is compared against the DUT
// on every falling edge. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_noc_rx_monitor;

    localparam int NPE  = 4;
    localparam int DW   = 32;
    localparam int ALSB = 4;
    localparam int AW   = 2;
    localparam int CW   = 32;
    localparam int EXP  = 400;
    localparam int DRN  = 50;
    localparam int TMO  = 20;

    localparam int P_RUN     = 0;
    localparam int P_DRAIN   = 1;
    localparam int P_DONE    = 2;
    localparam int P_TIMEOUT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_clear;
    logic [NPE-1:0]    i_valid;
    logic [NPE-1:0]    i_ready;
    logic [NPE*DW-1:0] i_data;
    logic [NPE*CW-1:0] o_per_pe_cnt;
    logic [CW-1:0]     o_total_cnt;
    logic [CW-1:0]     o_cycle_cnt;
    logic              o_done;
    logic              o_timeout;
    logic              o_overflow;
    logic              o_misroute;
    logic [1:0]        o_misroute_pe;
    logic [1:0]        o_state;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // reference model state
    int m_pe [NPE];
    int m_total, m_cycles, m_idle, m_phase, m_drain_left, m_mis_pe;
    bit m_ovf, m_mis;

    always #5 clk = ~clk;

    noc_rx_monitor #(
        .NUM_PE        (NPE),
        .DATA_W        (DW),
        .ADDR_LSB      (ALSB),
        .ADDR_W        (AW),
        .CNT_W         (CW),
        .EXPECTED_PKTS (EXP),
        .DRAIN_CYCLES  (DRN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (i_clear),
        .i_valid      (i_valid),
        .i_ready      (i_ready),
        .i_data       (i_data),
        .o_per_pe_cnt (o_per_pe_cnt),
        .o_total_cnt  (o_total_cnt),
        .o_cycle_cnt  (o_cycle_cnt),
        .o_done       (o_done),
        .o_timeout    (o_timeout),
        .o_overflow   (o_overflow),
        .o_misroute   (o_misroute),
        .o_misroute_pe(o_misroute_pe),
        .o_state      (o_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] flit(input int dest);
        logic [DW-1:0] d;
        d = $urandom;
        d[ALSB +: AW] = AW'(dest);
        return d;
    endfunction

    function automatic int pe_cnt(input int k);
        logic [NPE*CW-1:0] v;
        v = o_per_pe_cnt;
        return int'(v[k*CW +: CW]);
    endfunction

    function automatic int dest_of(input int k);
        logic [NPE*DW-1:0] v;
        v = i_data;
        return int'(v[k*DW+ALSB +: AW]);
    endfunction

    // ---------------- reference model (updated at each rising edge) -------
    initial begin
        forever begin
            int n, nt;
            @(posedge clk);
            if (rst || i_clear) begin
                for (int k = 0; k < NPE; k++) m_pe[k] = 0;
                m_total = 0; m_cycles = 0; m_idle = 0; m_phase = P_RUN;
                m_drain_left = 0; m_mis_pe = 0; m_ovf = 0; m_mis = 0;
            end else begin
                n = 0;
                for (int k = 0; k < NPE; k++) begin
                    if (i_valid[k] && i_ready[k]) begin
                        n++;
                        m_pe[k]++;
                        if (!m_mis && dest_of(k) != k) begin
                            m_mis = 1;
                            m_mis_pe = k;
                        end
                    end
                end
                nt = m_total + n;
                if (m_phase == P_RUN) begin
                    m_cycles++;
                    if (nt >= EXP) begin
                        m_phase = P_DRAIN;
                        m_drain_left = DRN;
                        if (nt > EXP) m_ovf = 1;
                    end else if (n == 0) begin
                        m_idle++;
                        if (m_idle >= TMO) m_phase = P_TIMEOUT;
                    end else begin
                        m_idle = 0;
                    end
                end else if (m_phase == P_DRAIN) begin
                    if (n > 0) m_ovf = 1;
                    m_drain_left--;
                    if (m_drain_left == 0) m_phase = P_DONE;
                end else if (m_phase == P_DONE) begin
                    if (n > 0) m_ovf = 1;
                end
                m_total = nt;
            end
        end
    end

    // ---------------- per-cycle compare against the model -----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < NPE; k++)
                    chk($sformatf("model_pe%0d", k), 64'(pe_cnt(k)), 64'(m_pe[k]));
                chk("model_total",    64'(o_total_cnt),   64'(m_total));
                chk("model_cycles",   64'(o_cycle_cnt),   64'(m_cycles));
                chk("model_state",    64'(o_state),       64'(m_phase));
                chk("model_done",     64'(o_done),        64'(m_phase == P_DONE));
                chk("model_timeout",  64'(o_timeout),     64'(m_phase == P_TIMEOUT));
                chk("model_overflow", 64'(o_overflow),    64'(m_ovf));
                chk("model_misroute", 64'(o_misroute),    64'(m_mis));
                chk("model_mis_pe",   64'(o_misroute_pe), 64'(m_mis_pe));
            end
        end
    end

    // ---------------- stimulus helpers -----------------------------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        i_valid = '0;
        i_ready = '0;
        for (int k = 0; k < NPE; k++)
            i_data[k*DW +: DW] = flit((k + 1) % NPE);
    endtask

    task automatic drive(input int k, input bit v, input bit r, input int dest);
        i_valid[k] = v;
        i_ready[k] = r;
        i_data[k*DW +: DW] = flit(dest);
    endtask

    task automatic do_clear();
        set_idle();
        i_clear = 1'b1;
        cyc();
        i_clear = 1'b0;
    endtask

    task automatic all_accept(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            for (int k = 0; k < NPE; k++) drive(k, 1, 1, k);
            cyc();
        end
        set_idle();
    endtask

    task automatic wait_done(input string name, input int expect_cycles);
        int n;
        n = 0;
        set_idle();
        while (!o_done && n < 4 * DRN) begin
            cyc();
            n++;
        end
        chk(name, 64'(n), 64'(expect_cycles));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    // ---------------- directed scenarios ----------------------------------
    initial begin
        int rem [NPE];
        int guard;
        bit r, pending;

        rst = 1'b1;
        i_clear = 1'b0;
        set_idle();
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_state", 64'(o_state), 64'd0);
        chk("reset_total", 64'(o_total_cnt), 64'd0);
        chk("reset_flags", 64'({o_done, o_timeout, o_overflow, o_misroute}), 64'd0);

        // 1: 100 flits per PE at random intervals
        for (int k = 0; k < NPE; k++) rem[k] = 100;
        guard = 0;
        pending = 1;
        while (pending && guard < 3000) begin
            for (int k = 0; k < NPE; k++) begin
                if (rem[k] > 0) begin
                    r = 1'($urandom_range(0, 1));
                    drive(k, 1, r, k);
                    if (r) rem[k]--;
                end else begin
                    drive(k, 1'($urandom_range(0, 1)), 0, (k + 1) % NPE);
                end
            end
            cyc();
            guard++;
            pending = 0;
            for (int k = 0; k < NPE; k++) if (rem[k] > 0) pending = 1;
        end
        set_idle();
        chk("t1_total", 64'(o_total_cnt), 64'd400);
        for (int k = 0; k < NPE; k++)
            chk($sformatf("t1_pe%0d", k), 64'(pe_cnt(k)), 64'd100);
        chk("t1_state_drain", 64'(o_state), 64'd1);
        wait_done("t1_drain_len", DRN);
        chk("t1_done", 64'(o_done), 64'd1);
        chk("t1_flags", 64'({o_timeout, o_overflow, o_misroute}), 64'd0);

        // 2: overshoot from 398 with all four channels at once
        do_clear();
        chk("t2_clear_done", 64'(o_done), 64'd0);
        all_accept(99);
        drive(0, 1, 1, 0);
        drive(1, 1, 1, 1);
        cyc();
        set_idle();
        chk("t2_total_398", 64'(o_total_cnt), 64'd398);
        chk("t2_state_run", 64'(o_state), 64'd0);
        all_accept(1);
        chk("t2_total_402", 64'(o_total_cnt), 64'd402);
        chk("t2_overflow", 64'(o_overflow), 64'd1);
        chk("t2_state_drain", 64'(o_state), 64'd1);

        // 6: clear during DRAIN with overflow set, then a clean run
        cyc();
        cyc();
        do_clear();
        chk("t6_total", 64'(o_total_cnt), 64'd0);
        chk("t6_pe3", 64'(pe_cnt(3)), 64'd0);
        chk("t6_cycles", 64'(o_cycle_cnt), 64'd0);
        chk("t6_overflow", 64'(o_overflow), 64'd0);
        chk("t6_state", 64'(o_state), 64'd0);
        all_accept(100);
        chk("t6_total_400", 64'(o_total_cnt), 64'd400);
        chk("t6_state_drain", 64'(o_state), 64'd1);
        chk("t6_no_overflow", 64'(o_overflow), 64'd0);
        wait_done("t6_drain_len", DRN);
        chk("t6_cycles_frozen", 64'(o_cycle_cnt), 64'd100);

        // 3: valid without ready on PE2 for 50 cycles, then one handshake
        do_clear();
        for (int i = 0; i < 50; i++) begin
            set_idle();
            drive(2, 1, 0, 1);
            if (i % 5 == 0) drive(0, 1, 1, 0);
            cyc();
        end
        set_idle();
        drive(2, 1, 1, 2);
        cyc();
        set_idle();
        chk("t3_pe2", 64'(pe_cnt(2)), 64'd1);
        chk("t3_pe0", 64'(pe_cnt(0)), 64'd10);
        chk("t3_total", 64'(o_total_cnt), 64'd11);
        chk("t3_no_misroute", 64'(o_misroute), 64'd0);

        // 4: misroute on channels 1 and 2 together, later on channel 0
        do_clear();
        drive(3, 1, 0, 0);
        cyc();
        chk("t4_unaccepted_ok", 64'(o_misroute), 64'd0);
        set_idle();
        drive(1, 1, 1, 3);
        drive(2, 1, 1, 0);
        drive(3, 1, 0, 0);
        cyc();
        set_idle();
        chk("t4_misroute", 64'(o_misroute), 64'd1);
        chk("t4_mis_pe", 64'(o_misroute_pe), 64'd1);
        cyc();
        drive(0, 1, 1, 2);
        cyc();
        set_idle();
        chk("t4_mis_pe_kept", 64'(o_misroute_pe), 64'd1);
        chk("t4_pe0", 64'(pe_cnt(0)), 64'd1);

        // 5: watchdog after 5 flits then silence
        do_clear();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 1);
            cyc();
        end
        set_idle();
        for (int i = 0; i < TMO - 1; i++) cyc();
        chk("t5_state_19", 64'(o_state), 64'd0);
        cyc();
        chk("t5_state_to", 64'(o_state), 64'd3);
        chk("t5_timeout", 64'(o_timeout), 64'd1);
        chk("t5_done", 64'(o_done), 64'd0);
        for (int i = 0; i < 5; i++) cyc();
        chk("t5_terminal", 64'(o_state), 64'd3);
        chk("t5_cycles", 64'(o_cycle_cnt), 64'd25);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
